// File: rtl/rr_grant_arbiter_pkg.sv
// Shared types and helpers for the round-robin grant arbiter.
// Helpers work on a MAX_W-wide vector; callers zero-extend and slice.
package rr_grant_arbiter_pkg;

    localparam int MAX_W     = 64;
    localparam int MAX_IDX_W = 6;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } arb_state_e;

    function automatic logic [MAX_IDX_W-1:0] onehot2bin(
        input logic [MAX_W-1:0] vec
    );
        logic [MAX_IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_W; i++) begin
            if (vec[i]) begin
                idx = idx | i[MAX_IDX_W-1:0];
            end
        end
        return idx;
    endfunction

    // Rotate left by one within the low w bits; bit w-1 wraps to bit 0.
    function automatic logic [MAX_W-1:0] rotl1(
        input logic [MAX_W-1:0] vec,
        input int               w
    );
        logic [MAX_W-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_W - 1; i++) begin
            if (i + 1 < w) begin
                r[i+1] = vec[i];
            end
        end
        for (int i = 0; i < MAX_W; i++) begin
            if (i == w - 1) begin
                r[0] = vec[i];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_grant_arbiter_if.sv
// Request/grant handshake bundle between the arbiter and its consumer.
interface rr_grant_arbiter_if #(
    parameter int WIDTH = 8,
    parameter int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
);
    logic [WIDTH-1:0] req;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] grant;
    logic [IDX_W-1:0] grant_idx;
    logic [WIDTH-1:0] base_q;

    modport master (
        input  req,
        input  out_ready,
        output out_valid,
        output grant,
        output grant_idx,
        output base_q
    );

    modport slave (
        output req,
        output out_ready,
        input  out_valid,
        input  grant,
        input  grant_idx,
        input  base_q
    );
endinterface

// File: rtl/rr_grant_arbiter_find_first1_base.sv
// Find-first-one starting at a one-hot base, wrapping past the top bit.
module find_first1_base #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] data_in,
    input  logic [WIDTH-1:0] base,
    output logic [WIDTH-1:0] result
);
    logic [WIDTH-1:0] upper;
    logic [WIDTH-1:0] pick;

    // Bits at or above the base win; otherwise wrap to the lowest set bit.
    always_comb begin
        upper  = data_in & ~(base - WIDTH'(1));
        pick   = (|upper) ? upper : data_in;
        result = pick & (~pick + WIDTH'(1));
    end
endmodule

// File: rtl/rr_grant_arbiter.sv
// Registered round-robin arbiter with held one-hot grant and valid/ready.
module rr_grant_arbiter
    import rr_grant_arbiter_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                flush,
    rr_grant_arbiter_if.master  bus
);
    arb_state_e       state_q;
    arb_state_e       state_d;
    logic [WIDTH-1:0] grant_q;
    logic [WIDTH-1:0] grant_d;
    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] idx_d;
    logic [WIDTH-1:0] base_r;
    logic [WIDTH-1:0] base_d;

    logic [WIDTH-1:0] arb_req;
    logic [WIDTH-1:0] arb_base;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] base_rot;
    logic [IDX_W-1:0] result_idx;

    logic [MAX_W-1:0]     grant_w;
    logic [MAX_W-1:0]     result_w;
    logic [MAX_W-1:0]     rot_w;
    logic [MAX_IDX_W-1:0] enc_w;

    always_comb begin
        grant_w               = '0;
        grant_w[WIDTH-1:0]    = grant_q;
        result_w              = '0;
        result_w[WIDTH-1:0]   = result;
        rot_w                 = rotl1(grant_w, WIDTH);
        enc_w                 = onehot2bin(result_w);
        base_rot              = rot_w[WIDTH-1:0];
        result_idx            = enc_w[IDX_W-1:0];
    end

    find_first1_base #(
        .WIDTH (WIDTH)
    ) u_ff1 (
        .data_in (arb_req),
        .base    (arb_base),
        .result  (result)
    );

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        idx_d    = idx_q;
        base_d   = base_r;
        arb_req  = bus.req;
        arb_base = base_r;
        unique case (state_q)
            IDLE: begin
                if (|bus.req) begin
                    grant_d = result;
                    idx_d   = result_idx;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                // Winner is masked so it must re-request for a cycle.
                arb_req  = bus.req & ~grant_q;
                arb_base = base_rot;
                if (bus.out_ready) begin
                    base_d = base_rot;
                    if (|arb_req) begin
                        grant_d = result;
                        idx_d   = result_idx;
                    end else begin
                        grant_d = '0;
                        idx_d   = '0;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (flush) begin
            state_d = IDLE;
            grant_d = '0;
            idx_d   = '0;
            base_d  = base_r;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            idx_q   <= '0;
            base_r  <= WIDTH'(1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            idx_q   <= idx_d;
            base_r  <= base_d;
        end
    end

    assign bus.out_valid = (state_q == HOLD);
    assign bus.grant     = grant_q;
    assign bus.grant_idx = idx_q;
    assign bus.base_q    = base_r;

    a_grant_shape: assert property (@(posedge clock) disable iff (!reset_n)
        $onehot0(grant_q) && ((grant_q != '0) == (state_q == HOLD)));

    a_base_onehot: assert property (@(posedge clock) disable iff (!reset_n)
        $onehot(base_r));

    a_idx_match: assert property (@(posedge clock) disable iff (!reset_n)
        (state_q == HOLD) ? (grant_q == (WIDTH'(1) << idx_q))
                          : (idx_q == '0));

    a_grant_stable: assert property (@(posedge clock) disable iff (!reset_n)
        (state_q == HOLD) && !bus.out_ready && !flush |=> $stable(grant_q));
endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Directed bench for rr_grant_arbiter at WIDTH=4.
module tb_rr_grant_arbiter;
    localparam int W = 4;

    logic clock;
    logic reset_n;
    logic flush;
    int   checks;
    int   errors;

    rr_grant_arbiter_if #(.WIDTH(W)) bus ();

    rr_grant_arbiter #(.WIDTH(W)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .flush   (flush),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic v,
                              input logic [3:0] g, input int idx,
                              input logic [3:0] b);
        check({tag, ".valid"}, 32'(bus.out_valid), 32'(v));
        check({tag, ".grant"}, 32'(bus.grant), 32'(g));
        check({tag, ".idx"}, 32'(bus.grant_idx), 32'(idx));
        check({tag, ".base"}, 32'(bus.base_q), 32'(b));
    endtask

    logic [3:0] rr_g [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    int         rr_i [5] = '{0, 1, 2, 3, 0};

    initial begin
        checks       = 0;
        errors       = 0;
        reset_n      = 1'b0;
        flush        = 1'b0;
        bus.req      = '0;
        bus.out_ready = 1'b0;
        step();
        step();
        expect_out("reset", 1'b0, 4'b0000, 0, 4'b0001);

        reset_n = 1'b1;
        bus.req = 4'b0110;
        step();
        expect_out("first", 1'b1, 4'b0010, 1, 4'b0001);

        bus.req = 4'b1001;
        step();
        expect_out("hold1", 1'b1, 4'b0010, 1, 4'b0001);
        bus.req = 4'b0000;
        step();
        expect_out("hold2", 1'b1, 4'b0010, 1, 4'b0001);
        step();
        expect_out("hold3", 1'b1, 4'b0010, 1, 4'b0001);
        bus.out_ready = 1'b1;
        step();
        expect_out("accept", 1'b0, 4'b0000, 0, 4'b0100);

        reset_n = 1'b0;
        bus.out_ready = 1'b0;
        step();
        reset_n = 1'b1;
        bus.req = 4'b1111;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            expect_out($sformatf("rr%0d", i), 1'b1, rr_g[i], rr_i[i], rr_g[i]);
        end

        bus.req = 4'b0100;
        step();
        expect_out("single0", 1'b1, 4'b0100, 2, 4'b0010);
        step();
        expect_out("single1", 1'b0, 4'b0000, 0, 4'b1000);
        step();
        expect_out("single2", 1'b1, 4'b0100, 2, 4'b1000);
        step();
        expect_out("single3", 1'b0, 4'b0000, 0, 4'b1000);

        bus.req = 4'b1000;
        bus.out_ready = 1'b0;
        step();
        expect_out("pre_flush", 1'b1, 4'b1000, 3, 4'b1000);
        flush = 1'b1;
        bus.out_ready = 1'b1;
        step();
        expect_out("flush_hold", 1'b0, 4'b0000, 0, 4'b1000);
        step();
        expect_out("flush_idle", 1'b0, 4'b0000, 0, 4'b1000);
        flush = 1'b0;

        bus.req = 4'b0100;
        bus.out_ready = 1'b0;
        step();
        expect_out("pre_rst", 1'b1, 4'b0100, 2, 4'b1000);
        reset_n = 1'b0;
        step();
        expect_out("rst_hold", 1'b0, 4'b0000, 0, 4'b0001);
        reset_n = 1'b1;
        bus.req = 4'b1010;
        step();
        expect_out("post_rst", 1'b1, 4'b0010, 1, 4'b0001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/rr_grant_arbiter.md
Name: rr_grant_arbiter

Overview:
- Registered round-robin arbiter that owns the rotating priority base and drives the shared find-first-one-from-base cell. It turns a request vector into a held, one-hot grant with a valid/ready handshake.
- Sits directly upstream of the find_first1_base cell: it produces that cell's base input and consumes its one-hot result.
- Used in front of shared resources: writeback port, dcache miss port, issue select.

Parameters:
- WIDTH, 8, number of requesters; must be ≥ 1.
- IDX_W, $clog2(WIDTH) (minimum 1), width of the encoded grant index.

Ports:
- clock  in  1  system clock; all state updates on its rising edge.
- reset_n  in  1  synchronous, active-low reset, sampled on the rising edge of clock.
- flush  in  1  synchronous; drops any pending grant; base pointer is kept.
- req  in  WIDTH  level request vector, one bit per requester.
- out_valid  out  1  grant registers hold a live grant.
- out_ready  in  1  consumer accepts the grant this cycle.
- grant  out  WIDTH  registered one-hot grant; all zero when out_valid=0.
- grant_idx  out  IDX_W  binary index of grant; 0 when out_valid=0.
- base_q  out  WIDTH  current one-hot priority base, for debug and perf.

Behaviour:
- State register with two states: IDLE (out_valid=0) and HOLD (out_valid=1).
- Reset (reset_n=0 at a clock edge):
  - state=IDLE, grant=0, grant_idx=0, base_q=1 (bit 0 set).
  - Reset wins over every other input, including mid-HOLD; the held grant is lost without a handshake.
- Arbitration is combinational through find_first1_base:
  - data_in = arb_req, base = arb_base.
  - The result is the lowest set bit of arb_req at or above the base position, wrapping past bit WIDTH-1 to bit 0.
  - The result is registered, so latency from req to out_valid is 1 cycle.
- IDLE:
  - arb_req = req, arb_base = base_q.
  - If |req: grant <= result, grant_idx <= encode(result), next state HOLD.
  - Otherwise stay in IDLE.
- HOLD without handshake (out_ready=0):
  - grant, grant_idx and base_q are held stable.
  - Changes on req are ignored, including the granted requester dropping its req; a grant, once issued, is committed.
- HOLD with handshake (out_ready=1):
  - base_q <= rotate-left-by-1 of grant, so the position above the winner gets top priority. Wrap: grant bit WIDTH-1 gives base bit 0. For WIDTH=1, base stays 1.
  - Back-to-back arbitration happens in the same cycle: arb_base = the rotated grant, arb_req = req & ~grant. The winner cannot be re-granted without one cycle of re-request.
  - If arb_req ≠ 0: load the new grant and stay in HOLD (one grant per cycle).
  - Otherwise: grant <= 0 and go to IDLE.
- flush (checked below reset, above everything else):
  - Next state IDLE, grant=0, grant_idx=0, base_q unchanged.
  - Flush together with out_ready in HOLD: the handshake is not counted and base_q is not rotated.
  - Flush in IDLE with |req: no grant is loaded.
- Invariants for assertions:
  - grant is one-hot or zero, and zero exactly when out_valid=0.
  - base_q is always one-hot.
  - grant_idx always matches grant.
  - The grant is stable while out_valid && !out_ready.
- Fairness: with all requesters continuously re-requesting, each is granted at least once every WIDTH handshakes.

Decomposition:
- Shared common package:
  - arb_state_e enum (IDLE, HOLD).
  - Function onehot2bin(vec) returning the index.
  - Function rotl1(vec) for the base update.
- One sub-module: the existing find_first1_base cell, a single instance with WIDTH passed through.
- The encode and rotate functions stay in the package, not in new modules.

Test Plan (WIDTH=4):
- Reset, then req=0110 in cycle 1 → cycle 2: out_valid=1, grant=0010, grant_idx=1, base_q=0001.
- Hold grant=0010, out_ready=0 for 3 cycles, req changes 0110→1001→0000 → grant stays 0010 each cycle. Then out_ready=1 → base_q=0100, and with req=0000 the next cycle is out_valid=0.
- req held at 1111, out_ready=1 every cycle → grants 0001, 0010, 0100, 1000, 0001… one per cycle. base_q wraps 1000→0001 after the grant on bit 3.
- Single requester req=0100 held, out_ready=1 → grant 0100, then one cycle with out_valid=0 (masked), then grant 0100 again; alternating pattern.
- HOLD with grant=1000, flush=1 and out_ready=1 in the same cycle → next cycle out_valid=0, grant=0000, base_q unchanged (not 0001).
- reset_n=0 asserted during HOLD with grant=0100 → next edge: out_valid=0, grant=0, base_q=0001. After release, req=1010 → grant=0010.
